// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage types and constants for the MIPS instruction fetch slice.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection: redirect target, hold, or sequential step.
module fetch_pc_reg
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        load_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Next-PC mux; a load wins over hold and word-aligns the target.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i & ALIGN_MASK;
    end else if (hold_i) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + PC_STEP;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: IDLE/RUN/HALT control FSM, PC sub-module and IF/ID pipeline register.
// Optional macro CTRL_HAZARD_FLUSH_EN squashes the wrong-path instruction on a redirect.
module inst_fetch
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          INST_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] InstAddr,
  input  logic [31:0] InstMemOut,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] IF_ID_Inst,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid,
  output logic        halted
);

  localparam logic [31:0] END_ADDR = 32'(INST_DEPTH * 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;
  logic         pc_hold_s;
  logic         pc_load_s;
  logic [31:0]  pc_s;
  logic [31:0]  pc_plus4_s;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .hold_i     (pc_hold_s),
    .load_i     (pc_load_s),
    .target_i   (redirect_target),
    .pc_o       (pc_s),
    .pc_plus4_o (pc_plus4_s)
  );

  // Next-state, PC control and IF/ID next values.
  always_comb begin
    state_d   = state_q;
    pc_hold_s = 1'b1;
    pc_load_s = 1'b0;
    inst_d    = inst_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE: begin
        state_d = RUN;
        inst_d  = NOP_INST;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
      end
      RUN: begin
        if (redirect) begin
          pc_hold_s = 1'b0;
          pc_load_s = 1'b1;
`ifdef CTRL_HAZARD_FLUSH_EN
          inst_d    = NOP_INST;
          pc4_d     = 32'h0000_0000;
          valid_d   = 1'b0;
`else
          inst_d    = InstMemOut;
          pc4_d     = pc_plus4_s;
          valid_d   = 1'b1;
`endif
        end else if (stall) begin
          pc_hold_s = 1'b1;
        end else begin
          pc_hold_s = 1'b0;
          inst_d    = InstMemOut;
          pc4_d     = pc_plus4_s;
          valid_d   = 1'b1;
          // Last word of memory: capture it, then park past the end.
          if (pc_plus4_s == END_ADDR) begin
            state_d = HALT;
          end else begin
            state_d = RUN;
          end
        end
      end
      HALT: begin
        inst_d  = NOP_INST;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
        if (redirect) begin
          pc_hold_s = 1'b0;
          pc_load_s = 1'b1;
          state_d   = RUN;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = IDLE;
        inst_d  = NOP_INST;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // FSM state and IF/ID pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      inst_q  <= NOP_INST;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign InstAddr    = pc_s;
  assign IF_ID_Inst  = inst_q;
  assign IF_ID_PC4   = pc4_q;
  assign IF_ID_Valid = valid_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus random stall/redirect traffic
// against a behavioural fetch model; honours CTRL_HAZARD_FLUSH_EN when defined.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 32;
  localparam int          M_IDLE   = 0;
  localparam int          M_RUN    = 1;
  localparam int          M_HALT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] inst_mem_out;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  logic [31:0] mem [DEPTH];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          fail_cnt = 0;

  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_pc4;
  logic        m_valid;

  inst_fetch #(
    .RESET_PC   (RESET_PC),
    .INST_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .InstAddr        (inst_addr),
    .InstMemOut      (inst_mem_out),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .IF_ID_Inst      (if_id_inst),
    .IF_ID_PC4       (if_id_pc4),
    .IF_ID_Valid     (if_id_valid),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    if (a < 32'(DEPTH * 4)) return mem[int'(a >> 2)];
    else return 32'hFFFF_FFFF;
  endfunction

  always_comb inst_mem_out = mem_at(inst_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " addr"},   inst_addr, m_pc);
    check({tag, " inst"},   if_id_inst, m_inst);
    check({tag, " pc4"},    if_id_pc4, m_pc4);
    check({tag, " valid"},  {31'd0, if_id_valid}, {31'd0, m_valid});
    check({tag, " halted"}, {31'd0, halted}, {31'd0, (m_state == M_HALT)});
  endtask

  task automatic model_bubble();
    m_inst  = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = RESET_PC;
    model_bubble();
  endtask

  // One clock of the fetch stage as described behaviourally.
  task automatic step(input logic s, input logic r, input logic [31:0] t, input string tag);
    stall           = s;
    redirect        = r;
    redirect_target = t;
    if (m_state == M_IDLE) begin
      m_state = M_RUN;
      model_bubble();
    end else if (m_state == M_RUN) begin
      if (r) begin
`ifdef CTRL_HAZARD_FLUSH_EN
        model_bubble();
`else
        m_inst  = mem_at(m_pc);
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
`endif
        m_pc = t & ~32'd3;
      end else if (!s) begin
        m_inst  = mem_at(m_pc);
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        if (m_pc == 32'(DEPTH * 4)) m_state = M_HALT;
      end
    end else begin
      model_bubble();
      if (r) begin
        m_pc    = t & ~32'd3;
        m_state = M_RUN;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    rst             = 1'b1;
    model_reset();
    #2 check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    step(1'b0, 1'b0, 32'h0, "idle");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, "straight");
    step(1'b1, 1'b0, 32'h0, "stall1");
    step(1'b1, 1'b0, 32'h0, "stall2");
    step(1'b0, 1'b0, 32'h0, "resume");
    step(1'b0, 1'b1, 32'h0000_000C, "redir_c");
    step(1'b0, 1'b1, 32'h0000_0040, "redirect");
    step(1'b1, 1'b1, 32'h0000_0023, "redir_stall");

    for (int i = 0; i < 80; i++) begin
      logic        rs;
      logic        rr;
      logic [31:0] rt;
      rs = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 7) == 0);
      rt = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
      step(rs, rr, rt, "random");
    end

    step(1'b0, 1'b1, 32'h0000_0070, "to_end");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, "run_end");
    step(1'b1, 1'b0, 32'h0, "halt_stall");
    step(1'b0, 1'b0, 32'h0, "halt_bubble");
    step(1'b0, 1'b1, 32'h0000_0000, "halt_exit");
    step(1'b0, 1'b0, 32'h0, "after_halt");
    step(1'b0, 1'b0, 32'h0, "after_halt");

    step(1'b1, 1'b0, 32'h0, "pre_rst_stall");
    pulse_reset("stall_rst");
    step(1'b0, 1'b0, 32'h0, "stall_rst_idle");
    step(1'b0, 1'b0, 32'h0, "stall_rst_fetch");

    step(1'b0, 1'b1, 32'h0000_0078, "to_end2");
    step(1'b0, 1'b0, 32'h0, "run_end2");
    step(1'b0, 1'b0, 32'h0, "run_end2");
    step(1'b0, 1'b0, 32'h0, "halt2");
    pulse_reset("halt_rst");
    step(1'b0, 1'b0, 32'h0, "halt_rst_idle");
    step(1'b0, 1'b0, 32'h0, "halt_rst_fetch");
    step(1'b0, 1'b0, 32'h0, "halt_rst_fetch");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
